store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart to the load-path extension logic in the MIPS pipeline.
- Takes SB/SH/SW requests from the MEM stage and narrows the 32-bit register value to the addressed byte or halfword lane.
- Sub-word stores use read-modify-write against a word-wide data memory that has no byte enables; SW writes directly.
- Sits between the EX/MEM pipeline register and data memory; the pipeline stalls while req_ready is low.

Parameters:
- MEM_LAT, default 1: data-memory read latency in cycles, from mem_rd_en to valid mem_rd_data. Legal range 1-4.
- ADDR_W, default 32: byte-address width. mem_addr is ADDR_W-2 bits wide.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  register value; low bits are used for sub-word stores.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
- mem_addr  out  ADDR_W-2  word address.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_data  in  32  read data, valid MEM_LAT cycles after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  32  merged write word.
- done  out  1  one-cycle pulse when the write issues.
- misalign  out  1  one-cycle misalignment pulse.

Behaviour:
- Reset is synchronous and active-high; the clock is Clk.
- Reset values: state=IDLE, mem_rd_en=0, mem_wr_en=0, done=0, misalign=0, mem_addr=0, mem_wr_data=0.
- Requests are ignored in any cycle where Reset is high.
- States are IDLE, RD, RD_WAIT, WRITE.
- req_ready = (state==IDLE). A request is accepted on an edge with req_valid & req_ready; addr, data and size are captured at that edge.
- IDLE transitions: word goes to WRITE; byte/half go to RD; misaligned requests go to IDLE (trap mode only).
- RD: mem_rd_en=1 and mem_addr=addr[ADDR_W-1:2]. Next state is RD_WAIT, with a counter loaded with MEM_LAT-1.
- RD_WAIT: count down. When the counter reaches 0, capture mem_rd_data at that edge and go to WRITE.
- WRITE: mem_wr_en=1 and done=1 for exactly one cycle, then go to IDLE.
- Latency from accept edge T:
  - SW writes in cycle T+1, with req_ready high again in T+2.
  - SB/SH: rd_en in T+1, write in T+2+MEM_LAT.
- Merge rule is little-endian, with lane = addr[1:0].
  - Byte: bits [8k+7:8k] take req_data[7:0] for k=addr[1:0].
  - Half: bits [16h+15:16h] take req_data[15:0] for h=addr[1].
  - Word: req_data passes through unchanged.
  - All other bits keep the captured read word.
- mem_addr holds its last value outside RD/WRITE.
- mem_wr_data is don't-care outside WRITE but must be stable across WRITE.
- Reset in any state aborts the operation with no write issued. The in-flight request is dropped; the pipeline re-issues it.
- Back-to-back requests: no accept in a WRITE cycle; the next accept is possible in the following IDLE cycle.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request is half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - It is accepted, no memory access occurs, misalign pulses in T+1, done stays 0, and state stays IDLE.
- Undefined:
  - misalign is tied to 0.
  - Low address bits are forced to zero (half: addr[0]; word: addr[1:0]).
  - Size 11 is treated as word.
  - The store proceeds normally.

Decomposition:
- Package store_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - the state enum;
  - the misalignment predicate function.
- One combinational sub-module, store_lane_merge, computes (old_word, data, size, addr[1:0]) -> merged word. The FSM, counter and registers stay in the top level.

Test Plan:
1. Reset 2 cycles, then SW addr 0x100 data 0xDEADBEEF -> T+1: mem_wr_en=1, mem_addr=0x40, wr_data=0xDEADBEEF, done=1; mem_rd_en never high.
2. SB addr 0x103 data 0x000000AA, mem_rd_data=0x11223344, MEM_LAT=1 -> rd_en at T+1 with mem_addr=0x40; write at T+3 with wr_data=0xAA223344.
3. SH addr 0x102 data 0x00005566, read word 0x11223344 -> wr_data=0x55663344; MEM_LAT=3 places the write at T+5.
4. SH addr 0x101 data 0x5566:
   - with STORE_MISALIGN_TRAP_EN: misalign=1 at T+1, no rd/wr strobes, done=0;
   - without it: wr_data=0x11225566.
5. Reset asserted during RD_WAIT -> mem_wr_en never asserts, all outputs at reset values, req_ready=1 in the first cycle after Reset deasserts.
6. req_valid held high with two SW requests -> accepts at T and T+2, writes at T+1 and T+3, exactly two done pulses.

Source files
------------

// File: rtl/store_merge_unit_pkg.sv
// Shared types for the store merge unit: size codes, FSM states, misalignment predicate.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RD      = 2'b01,
    S_RD_WAIT = 2'b10,
    S_WRITE   = 2'b11
  } state_e;

  // True when the size/low-address pair cannot be stored as a naturally aligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      SZ_RSVD: mis = 1'b1;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian lane insert: overlays the store data onto the old memory word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged_word_c
);

  // Replace only the addressed byte/halfword; word stores pass straight through.
  always_comb begin
    merged_word_c = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged_word_c[7:0]   = data[7:0];
          2'd1:    merged_word_c[15:8]  = data[7:0];
          2'd2:    merged_word_c[23:16] = data[7:0];
          default: merged_word_c[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged_word_c[31:16] = data[15:0];
        else         merged_word_c[15:0]  = data[15:0];
      end
      default: merged_word_c = data;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: SW writes directly, SB/SH do read-modify-write on a word-only memory.
// Optional build macro STORE_MISALIGN_TRAP_EN: misaligned requests pulse misalign instead of
// being silently aligned.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              misalign
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned WA_W  = ADDR_W - 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic [WA_W-1:0]    mem_addr_q, mem_addr_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic [31:0]        mem_wr_data_q, mem_wr_data_d;
  logic               done_q, done_d;
  logic               misalign_q, misalign_d;

  logic [1:0]         eff_size_c;
  logic [1:0]         eff_lane_c;
  logic               req_mis_c;
  logic [31:0]        mrg_data_c;
  logic [1:0]         mrg_size_c;
  logic [1:0]         mrg_lane_c;
  logic [31:0]        merged_c;

  // Request normalisation: trap on misalignment, or force natural alignment.
  always_comb begin
    eff_size_c = req_size;
    eff_lane_c = req_addr[1:0];
`ifdef STORE_MISALIGN_TRAP_EN
    req_mis_c  = is_misaligned(req_size, req_addr[1:0]);
`else
    req_mis_c  = 1'b0;
    if (req_size == SZ_RSVD) eff_size_c = SZ_WORD;
    if (eff_size_c == SZ_HALF) eff_lane_c[0] = 1'b0;
    if (eff_size_c == SZ_WORD) eff_lane_c    = 2'b00;
`endif
  end

  // Merge operands come from the live request in IDLE, from the captured request otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      mrg_data_c = req_data;
      mrg_size_c = eff_size_c;
      mrg_lane_c = eff_lane_c;
    end else begin
      mrg_data_c = data_q;
      mrg_size_c = size_q;
      mrg_lane_c = lane_q;
    end
  end

  store_lane_merge u_merge (
    .old_word      (mem_rd_data),
    .data          (mrg_data_c),
    .size          (mrg_size_c),
    .lane          (mrg_lane_c),
    .merged_word_c (merged_c)
  );

  // Next-state and registered strobe computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    size_d        = size_q;
    lane_d        = lane_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    done_d        = 1'b0;
    misalign_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          data_d = req_data;
          size_d = eff_size_c;
          lane_d = eff_lane_c;
          if (req_mis_c) begin
            misalign_d = 1'b1;
          end else if (eff_size_c == SZ_WORD) begin
            state_d       = S_WRITE;
            mem_addr_d    = req_addr[ADDR_W-1:2];
            mem_wr_data_d = merged_c;
            mem_wr_en_d   = 1'b1;
            done_d        = 1'b1;
          end else begin
            state_d     = S_RD;
            mem_addr_d  = req_addr[ADDR_W-1:2];
            mem_rd_en_d = 1'b1;
          end
        end
      end
      S_RD: begin
        state_d = S_RD_WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d       = S_WRITE;
          mem_wr_data_d = merged_c;
          mem_wr_en_d   = 1'b1;
          done_d        = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any in-flight store.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      data_q        <= '0;
      size_q        <= SZ_BYTE;
      lane_q        <= '0;
      mem_addr_q    <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
      misalign_q    <= misalign_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign done        = done_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (MEM_LAT=1 and 3) share request stimulus;
// expected memory events are queued at accept time and matched as the DUTs emit them.
module tb_store_merge_unit;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_MIS = 2;

  typedef struct {
    int          inst;
    int          kind;
    int          cyc;
    logic [29:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_word = '0;

  logic        rdy    [2];
  logic [29:0] maddr  [2];
  logic        rd_en  [2];
  logic [31:0] rdata  [2];
  logic        wr_en  [2];
  logic [31:0] wdata  [2];
  logic        dn     [2];
  logic        mis    [2];

  logic [3:0]  pipe0 = '0;
  logic [3:0]  pipe1 = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt [2];
  ev_t sb [$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory models: read data is valid only MEM_LAT cycles after the read strobe.
  always @(posedge Clk) begin
    pipe0 <= {pipe0[2:0], rd_en[0]};
    pipe1 <= {pipe1[2:0], rd_en[1]};
  end
  assign rdata[0] = pipe0[0] ? mem_word : 32'hBAD0_BAD0;
  assign rdata[1] = pipe1[2] ? mem_word : 32'hBAD0_BAD0;

  store_merge_unit #(.MEM_LAT(1), .ADDR_W(32)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(maddr[0]), .mem_rd_en(rd_en[0]), .mem_rd_data(rdata[0]),
    .mem_wr_en(wr_en[0]), .mem_wr_data(wdata[0]), .done(dn[0]), .misalign(mis[0])
  );

  store_merge_unit #(.MEM_LAT(3), .ADDR_W(32)) dut_l3 (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(maddr[1]), .mem_rd_en(rd_en[1]), .mem_rd_data(rdata[1]),
    .mem_wr_en(wr_en[1]), .mem_wr_data(wdata[1]), .done(dn[1]), .misalign(mis[1])
  );

  // Reference merge built from byte masks.
  function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    logic [31:0] ins;
    if (sz == 2'b00) begin
      mask = 32'h0000_00FF << (8 * lo);
      ins  = (d & 32'h0000_00FF) << (8 * lo);
    end else if (sz == 2'b01) begin
      mask = 32'h0000_FFFF << (16 * int'(lo[1]));
      ins  = (d & 32'h0000_FFFF) << (16 * int'(lo[1]));
    end else begin
      mask = 32'hFFFF_FFFF;
      ins  = d;
    end
    return (old & ~mask) | ins;
  endfunction

  // Scoreboard monitor: every strobe must match the oldest queued event of that kind.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dn[i]) done_cnt[i] = done_cnt[i] + 1;
      if (dn[i] !== wr_en[i]) begin
        checks++; errors++;
        $display("FAIL done_vs_wr inst%0d cyc %0d: done=%b wr_en=%b, required equal", i, cyc, dn[i], wr_en[i]);
      end
      for (int k = 0; k < 3; k++) begin
        logic seen;
        int idx;
        seen = (k == K_RD) ? rd_en[i] : (k == K_WR) ? wr_en[i] : mis[i];
        if (seen === 1'b1) begin
          idx = -1;
          foreach (sb[j]) if (idx < 0 && sb[j].inst == i && sb[j].kind == k) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_event inst%0d kind%0d cyc %0d: strobe=1, required 0", i, k, cyc);
          end else begin
            if (sb[idx].cyc != cyc ||
                (k != K_MIS && maddr[i] !== sb[idx].addr) ||
                (k == K_WR && wdata[i] !== sb[idx].data)) begin
              errors++;
              $display("FAIL event inst%0d kind%0d: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                       i, k, cyc, maddr[i], wdata[i], sb[idx].cyc, sb[idx].addr, sb[idx].data);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic push_ev(input int inst, input int kind, input int c,
                         input logic [29:0] a, input logic [31:0] d);
    ev_t e;
    e.inst = inst; e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 40; n++) begin
      @(posedge Clk); #1;
      if (sb.size() == 0 && rdy[0] && rdy[1]) break;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_idle timeout: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue one request (both DUTs idle), queue its expected events, wait until retired.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic [31:0] rw);
    int t;
    logic [1:0] esz;
    logic [1:0] lane;
    mem_word = rw; req_addr = a; req_data = d; req_size = sz; req_valid = 1'b1;
    @(posedge Clk); #1;
    t = cyc;
    req_valid = 1'b0;
    esz = sz;
    lane = a[1:0];
`ifdef STORE_MISALIGN_TRAP_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || sz == 2'b11) begin
      push_ev(0, K_MIS, t, '0, '0);
      push_ev(1, K_MIS, t, '0, '0);
      wait_idle();
      return;
    end
`else
    if (esz == 2'b11) esz = 2'b10;
    if (esz == 2'b01) lane[0] = 1'b0;
    if (esz == 2'b10) lane = 2'b00;
`endif
    for (int i = 0; i < 2; i++) begin
      if (esz == 2'b10) begin
        push_ev(i, K_WR, t, a[31:2], d);
      end else begin
        push_ev(i, K_RD, t, a[31:2], '0);
        push_ev(i, K_WR, t + 1 + (i == 0 ? 1 : 3), a[31:2], exp_merge(rw, d, esz, lane));
      end
    end
    wait_idle();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rd_en[i], wr_en[i], dn[i], mis[i]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_strobes inst%0d: %b, required 0000", i, {rd_en[i], wr_en[i], dn[i], mis[i]});
      end
      checks++;
      if (maddr[i] !== 30'h0 || wdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_regs inst%0d: addr=%h wdata=%h, required 0/0", i, maddr[i], wdata[i]);
      end
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready inst%0d: %b, required 1", i, rdy[i]);
      end
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_sw();
    do_req(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 32'h0);
    do_req(32'h0000_0FFC, 32'h0123_4567, 2'b10, 32'hFFFF_FFFF);
  endtask

  task automatic test_sb();
    do_req(32'h0000_0103, 32'h0000_00AA, 2'b00, 32'h1122_3344);
    for (int k = 0; k < 4; k++)
      do_req(32'h0000_0200 + 32'(k), 32'hFFFF_FF00 | 32'(8'h5A + k), 2'b00, 32'hCAFE_F00D);
  endtask

  task automatic test_sh();
    do_req(32'h0000_0102, 32'h0000_5566, 2'b01, 32'h1122_3344);
    do_req(32'h0000_0300, 32'hABCD_9876, 2'b01, 32'h0F0F_0F0F);
  endtask

  task automatic test_misalign();
    do_req(32'h0000_0101, 32'h0000_5566, 2'b01, 32'h1122_3344);
    do_req(32'h0000_0107, 32'h7654_3210, 2'b11, 32'h1122_3344);
    do_req(32'h0000_010A, 32'h89AB_CDEF, 2'b10, 32'h1122_3344);
  endtask

  task automatic test_reset_abort();
    int t;
    mem_word = 32'h1122_3344; req_addr = 32'h0000_0401; req_data = 32'h0000_0077;
    req_size = 2'b00; req_valid = 1'b1;
    @(posedge Clk); #1;
    t = cyc;
    req_valid = 1'b0;
    push_ev(0, K_RD, t, 30'h100, '0);
    push_ev(1, K_RD, t, 30'h100, '0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rd_en[i], wr_en[i], dn[i], mis[i]} !== 4'b0000 || maddr[i] !== 30'h0 || wdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL abort_reset_vals inst%0d: strobes=%b addr=%h wdata=%h, required 0",
                 i, {rd_en[i], wr_en[i], dn[i], mis[i]}, maddr[i], wdata[i]);
      end
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL abort_ready inst%0d: %b, required 1", i, rdy[i]);
      end
    end
    repeat (6) @(posedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL abort_pending: %0d events unseen, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int d0;
    int d1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    req_addr = 32'h0000_0500; req_data = 32'h1111_2222; req_size = 2'b10; req_valid = 1'b1;
    @(posedge Clk); #1;
    t1 = cyc;
    push_ev(0, K_WR, t1, 30'h140, 32'h1111_2222);
    push_ev(1, K_WR, t1, 30'h140, 32'h1111_2222);
    req_addr = 32'h0000_0504; req_data = 32'h3333_4444;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_write inst%0d: %b, required 0", i, rdy[i]);
      end
    end
    @(posedge Clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_idle inst%0d: %b, required 1", i, rdy[i]);
      end
    end
    @(posedge Clk); #1;
    req_valid = 1'b0;
    push_ev(0, K_WR, t1 + 2, 30'h141, 32'h3333_4444);
    push_ev(1, K_WR, t1 + 2, 30'h141, 32'h3333_4444);
    wait_idle();
    checks++;
    if (done_cnt[0] - d0 != 2 || done_cnt[1] - d1 != 2) begin
      errors++;
      $display("FAIL b2b_done_count: %0d/%0d pulses, required 2/2", done_cnt[0] - d0, done_cnt[1] - d1);
    end
  endtask

  task automatic test_random_subword();
    for (int n = 0; n < 8; n++)
      do_req(32'h0000_0800 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 1)), $urandom);
  endtask

  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misalign();
    test_reset_abort();
    test_back_to_back();
    test_random_subword();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d events unseen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
